// File: rtl/lz4_match_addr_gen.sv
// LZ4 match copy address generator: tracks the output write pointer and splits each match into 1..4 byte copy beats.
// Optional offset legality checking is compiled in with the LZ4_OFFSET_CHECK_EN macro.
module lz4_match_addr_gen #(
    parameter logic [31:0] RST_WR_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [2:0]  lit_incr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_offset,
    input  logic [15:0] cmd_len,
    output logic        copy_valid,
    input  logic        copy_ready,
    output logic [31:0] rd_addr,
    output logic [31:0] wr_addr,
    output logic [2:0]  copy_bytes,
    output logic        err_offset
);

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wr_q, wr_d;
    logic [31:0] rd_q, rd_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] off_q, off_d;
    logic [2:0]  bytes_q, bytes_d;
    logic [31:0] base;
    logic [15:0] rem_after;
    logic        illegal;

    // Beat size: never past the end of the match, never more than 4 bytes, and never
    // more than the offset so every source byte already exists. Offset 0 is treated as
    // unbounded so the match still terminates after its length.
    function automatic logic [2:0] beat_len(input logic [15:0] rem, input logic [15:0] off);
        logic [2:0] n;
        n = 3'd4;
        if (off != 16'd0 && off < 16'd4) n = off[2:0];
        if (rem < {13'd0, n}) n = rem[2:0];
        return n;
    endfunction

    assign base      = wr_q + {29'd0, lit_incr};
    assign rem_after = rem_q - {13'd0, bytes_q};

`ifdef LZ4_OFFSET_CHECK_EN
    logic err_q, err_d;

    assign illegal    = (cmd_offset == 16'd0) || ({16'd0, cmd_offset} > base);
    assign err_d      = err_q | ((state_q == IDLE) && cmd_valid && illegal);
    assign err_offset = err_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign illegal    = 1'b0;
    assign err_offset = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        off_d   = off_q;
        bytes_d = bytes_q;
        unique case (state_q)
            IDLE: begin
                wr_d = base;
                if (cmd_valid && !illegal && cmd_len != 16'd0) begin
                    state_d = COPY;
                    rem_d   = cmd_len;
                    off_d   = cmd_offset;
                    rd_d    = base - {16'd0, cmd_offset};
                    bytes_d = beat_len(cmd_len, cmd_offset);
                end
            end
            COPY: begin
                if (copy_ready) begin
                    wr_d  = wr_q + {29'd0, bytes_q};
                    rd_d  = rd_q + {29'd0, bytes_q};
                    rem_d = rem_after;
                    if (rem_q == {13'd0, bytes_q}) begin
                        state_d = IDLE;
                        bytes_d = 3'd0;
                    end else begin
                        bytes_d = beat_len(rem_after, off_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            wr_q    <= RST_WR_ADDR;
            rd_q    <= 32'd0;
            rem_q   <= 16'd0;
            off_q   <= 16'd0;
            bytes_q <= 3'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            off_q   <= off_d;
            bytes_q <= bytes_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign copy_valid = (state_q == COPY);
    assign rd_addr    = rd_q;
    assign wr_addr    = wr_q;
    assign copy_bytes = bytes_q;

endmodule

// File: tb/tb_lz4_match_addr_gen.sv
// Directed, table-driven bench for lz4_match_addr_gen; a second instance with a high
// reset write pointer exercises 32-bit wrap. Expectations follow LZ4_OFFSET_CHECK_EN.
module tb_lz4_match_addr_gen;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  lit_incr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_offset;
    logic [15:0] cmd_len;
    logic        copy_valid;
    logic        copy_ready;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [2:0]  copy_bytes;
    logic        err_offset;

    logic [2:0]  w_lit;
    logic        w_cmd_valid;
    logic        w_cmd_ready;
    logic [15:0] w_cmd_offset;
    logic [15:0] w_cmd_len;
    logic        w_copy_valid;
    logic        w_copy_ready;
    logic [31:0] w_rd_addr;
    logic [31:0] w_wr_addr;
    logic [2:0]  w_copy_bytes;
    logic        w_err_offset;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_wr;

    typedef struct {
        int          pad;
        logic [2:0]  lit;
        logic [15:0] off;
        logic [15:0] len;
        int          n;
        logic [31:0] rd [5];
        logic [2:0]  bytes [5];
        logic [31:0] wr_end;
    } vec_t;

    vec_t vecs[$];

    lz4_match_addr_gen dut (
        .clk        (clk),
        .rstN       (rstN),
        .lit_incr   (lit_incr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_offset (cmd_offset),
        .cmd_len    (cmd_len),
        .copy_valid (copy_valid),
        .copy_ready (copy_ready),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .copy_bytes (copy_bytes),
        .err_offset (err_offset)
    );

    lz4_match_addr_gen #(.RST_WR_ADDR(32'hFFFF_FFF0)) u_wrap (
        .clk        (clk),
        .rstN       (rstN),
        .lit_incr   (w_lit),
        .cmd_valid  (w_cmd_valid),
        .cmd_ready  (w_cmd_ready),
        .cmd_offset (w_cmd_offset),
        .cmd_len    (w_cmd_len),
        .copy_valid (w_copy_valid),
        .copy_ready (w_copy_ready),
        .rd_addr    (w_rd_addr),
        .wr_addr    (w_wr_addr),
        .copy_bytes (w_copy_bytes),
        .err_offset (w_err_offset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int pad, input logic [2:0] lit, input logic [15:0] off,
                           input logic [15:0] len, input int n, input logic [31:0] wr_end,
                           input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input logic [31:0] r4,
                           input logic [2:0] b0, input logic [2:0] b1, input logic [2:0] b2,
                           input logic [2:0] b3, input logic [2:0] b4);
        vec_t v;
        v.pad = pad; v.lit = lit; v.off = off; v.len = len; v.n = n; v.wr_end = wr_end;
        v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2; v.rd[3] = r3; v.rd[4] = r4;
        v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.bytes[3] = b3; v.bytes[4] = b4;
        vecs.push_back(v);
    endtask

    // Pads wr_addr with literal cycles, issues one command with copy_ready held high,
    // then compares every beat and the final pointer against the vector.
    task automatic run_vec(input int idx);
        vec_t        v;
        int          pad;
        int          nb;
        logic [31:0] got_rd [5];
        logic [31:0] got_wr [5];
        logic [2:0]  got_b  [5];
        logic [31:0] exp_w;
        v   = vecs[idx];
        pad = v.pad;
        while (pad > 0) begin
            lit_incr = (pad > 7) ? 3'd7 : 3'(pad);
            pad -= int'(lit_incr);
            tick();
        end
        exp_w      = exp_wr + 32'(v.pad) + 32'(v.lit);
        lit_incr   = v.lit;
        cmd_valid  = 1'b1;
        cmd_offset = v.off;
        cmd_len    = v.len;
        copy_ready = 1'b1;
        check($sformatf("v%0d cmd_ready at accept", idx), 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        lit_incr  = 3'd0;
        nb = 0;
        while (copy_valid === 1'b1 && nb < 40) begin
            if (nb < 5) begin
                got_rd[nb] = rd_addr;
                got_wr[nb] = wr_addr;
                got_b[nb]  = copy_bytes;
            end
            nb++;
            tick();
        end
        check($sformatf("v%0d beat count", idx), 32'(nb), 32'(v.n));
        for (int i = 0; i < v.n && i < nb && i < 5; i++) begin
            check($sformatf("v%0d beat%0d rd_addr", idx, i), got_rd[i], v.rd[i]);
            check($sformatf("v%0d beat%0d wr_addr", idx, i), got_wr[i], exp_w);
            check($sformatf("v%0d beat%0d copy_bytes", idx, i), 32'(got_b[i]), 32'(v.bytes[i]));
            exp_w += 32'(v.bytes[i]);
        end
        check($sformatf("v%0d final wr_addr", idx), wr_addr, v.wr_end);
        check($sformatf("v%0d cmd_ready after", idx), 32'(cmd_ready), 32'd1);
        exp_wr = v.wr_end;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_rd, hold_wr;
        logic [2:0]  hold_b;

        // pad lit off len n wr_end | rd0..rd4 | bytes0..bytes4
        add_vec(35, 3'd0, 16'd1,  16'd5,  5, 32'd55,  49, 50, 51, 52, 53, 1, 1, 1, 1, 1);
        add_vec(0,  3'd0, 16'd3,  16'd7,  3, 32'd62,  52, 55, 58, 0, 0,   3, 3, 1, 0, 0);
        add_vec(38, 3'd0, 16'd20, 16'd10, 3, 32'd110, 80, 84, 88, 0, 0,   4, 4, 2, 0, 0);
        add_vec(0,  3'd0, 16'd5,  16'd0,  0, 32'd110, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add_vec(0,  3'd5, 16'd15, 16'd6,  2, 32'd121, 100, 104, 0, 0, 0,  4, 2, 0, 0, 0);
        add_vec(0,  3'd0, 16'd4,  16'd8,  2, 32'd129, 117, 121, 0, 0, 0,  4, 4, 0, 0, 0);
        // index 6..8: used after the mid-copy reset
        add_vec(0,  3'd6, 16'd6,  16'd3,  1, 32'd9,   0, 0, 0, 0, 0,      3, 0, 0, 0, 0);
`ifdef LZ4_OFFSET_CHECK_EN
        add_vec(1,  3'd0, 16'd11, 16'd4,  0, 32'd10,  0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add_vec(0,  3'd0, 16'd2,  16'd2,  1, 32'd12,  8, 0, 0, 0, 0,      2, 0, 0, 0, 0);
`else
        add_vec(1,  3'd0, 16'd11, 16'd4,  1, 32'd14,  32'hFFFF_FFFF, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        add_vec(0,  3'd0, 16'd2,  16'd2,  1, 32'd16,  12, 0, 0, 0, 0,     2, 0, 0, 0, 0);
`endif

        rstN = 1'b0;
        lit_incr = 3'd0; cmd_valid = 1'b0; cmd_offset = 16'd0; cmd_len = 16'd0; copy_ready = 1'b0;
        w_lit = 3'd0; w_cmd_valid = 1'b0; w_cmd_offset = 16'd0; w_cmd_len = 16'd0; w_copy_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset copy_valid", 32'(copy_valid), 32'd0);
        check("reset wr_addr", wr_addr, 32'd0);
        check("reset rd_addr", rd_addr, 32'd0);
        check("reset copy_bytes", 32'(copy_bytes), 32'd0);
        check("reset err_offset", 32'(err_offset), 32'd0);

        lit_incr = 3'd5; tick();
        lit_incr = 3'd3; tick();
        lit_incr = 3'd7; tick();
        lit_incr = 3'd0;
        check("literal wr_addr", wr_addr, 32'd15);
        exp_wr = 32'd15;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Stall on the second beat with literals asserted: beat must hold, pointer must not move.
        cmd_valid = 1'b1; cmd_offset = 16'd8; cmd_len = 16'd12; copy_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("stall beat0 rd", rd_addr, 32'd121);
        check("stall beat0 wr", wr_addr, 32'd129);
        tick();
        copy_ready = 1'b0; lit_incr = 3'd7;
        hold_rd = rd_addr; hold_wr = wr_addr; hold_b = copy_bytes;
        check("stall beat1 rd", hold_rd, 32'd125);
        check("stall beat1 wr", hold_wr, 32'd133);
        check("stall beat1 bytes", 32'(hold_b), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d valid", i), 32'(copy_valid), 32'd1);
            check($sformatf("stall%0d rd", i), rd_addr, 32'd125);
            check($sformatf("stall%0d wr", i), wr_addr, 32'd133);
            check($sformatf("stall%0d bytes", i), 32'(copy_bytes), 32'd4);
        end
        copy_ready = 1'b1;
        tick();
        lit_incr = 3'd0;
        check("stall beat2 rd", rd_addr, 32'd129);
        check("stall beat2 wr", wr_addr, 32'd137);
        check("stall beat2 bytes", 32'(copy_bytes), 32'd4);
        tick();
        check("stall end wr", wr_addr, 32'd141);
        check("stall end cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset asserted while the second beat of a 16-byte match is presented.
        cmd_valid = 1'b1; cmd_offset = 16'd16; cmd_len = 16'd16;
        tick();
        cmd_valid = 1'b0;
        check("midrst beat0 rd", rd_addr, 32'd125);
        tick();
        check("midrst beat1 wr", wr_addr, 32'd145);
        rstN = 1'b0;
        #1;
        check("midrst copy_valid", 32'(copy_valid), 32'd0);
        check("midrst wr_addr", wr_addr, 32'd0);
        check("midrst rd_addr", rd_addr, 32'd0);
        check("midrst copy_bytes", 32'(copy_bytes), 32'd0);
        check("midrst err_offset", 32'(err_offset), 32'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post-rst copy_valid", 32'(copy_valid), 32'd0);
        check("post-rst wr_addr", wr_addr, 32'd0);
        exp_wr = 32'd0;

        run_vec(6);
        run_vec(7);
`ifdef LZ4_OFFSET_CHECK_EN
        check("illegal offset err", 32'(err_offset), 32'd1);
`else
        check("no-check err tied", 32'(err_offset), 32'd0);
`endif
        run_vec(8);
`ifdef LZ4_OFFSET_CHECK_EN
        check("err sticky", 32'(err_offset), 32'd1);
`else
        check("no-check err tied later", 32'(err_offset), 32'd0);
`endif

        // Wrap instance: reset pointer 0xFFFFFFF0, pad to 0xFFFFFFFE, then offset 2 len 4.
        check("wrap reset wr", w_wr_addr, 32'hFFFF_FFF0);
        w_lit = 3'd7; tick(); tick();
        w_lit = 3'd0;
        check("wrap pad wr", w_wr_addr, 32'hFFFF_FFFE);
        w_cmd_valid = 1'b1; w_cmd_offset = 16'd2; w_cmd_len = 16'd4; w_copy_ready = 1'b1;
        tick();
        w_cmd_valid = 1'b0;
        check("wrap beat0 valid", 32'(w_copy_valid), 32'd1);
        check("wrap beat0 rd", w_rd_addr, 32'hFFFF_FFFC);
        check("wrap beat0 wr", w_wr_addr, 32'hFFFF_FFFE);
        check("wrap beat0 bytes", 32'(w_copy_bytes), 32'd2);
        tick();
        check("wrap beat1 rd", w_rd_addr, 32'hFFFF_FFFE);
        check("wrap beat1 wr", w_wr_addr, 32'd0);
        check("wrap beat1 bytes", 32'(w_copy_bytes), 32'd2);
        tick();
        check("wrap end valid", 32'(w_copy_valid), 32'd0);
        check("wrap end wr", w_wr_addr, 32'd2);
        check("wrap end cmd_ready", 32'(w_cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lz4_match_addr_gen.md
LZ4_MATCH_ADDR_GEN -- requirements
Module: lz4_match_addr_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rstN input 1, async active-low reset.
REQ-002 The block SHALL have `lit_incr` (input, 3): literal bytes written this cycle, 0..7.
REQ-003 The block SHALL have `cmd_valid` (input, 1): match command present.
REQ-004 The block SHALL have `cmd_ready` (output, 1): block accepts a command this cycle.
REQ-005 The block SHALL have `cmd_offset` (input, 16): match back-distance in bytes.
REQ-006 The block SHALL have `cmd_len` (input, 16): match length in bytes.
REQ-007 The block SHALL have `copy_valid` (output, 1): a copy beat is presented.
REQ-008 The block SHALL have `copy_ready` (input, 1): downstream accepts the beat.
REQ-009 The block SHALL have `rd_addr` (output, 32): absolute source address of the beat.
REQ-010 The block SHALL have `wr_addr` (output, 32): absolute output address, which is the write pointer.
REQ-011 The block SHALL have `copy_bytes` (output, 3): bytes in the beat, 1..4.
REQ-012 The block SHALL have `err_offset` (output, 1): sticky illegal-offset flag.

Function
REQ-013 The block SHALL have two states: IDLE and COPY. `cmd_ready` SHALL be 1 exactly when the state is IDLE.
REQ-014 In IDLE, `wr_addr` SHALL advance by `lit_incr` every cycle. In COPY, `lit_incr` SHALL be ignored.
REQ-015 A command SHALL be accepted when `cmd_valid` and `cmd_ready` are both 1. The base address for that command SHALL be wr_addr + lit_incr of the same cycle.
REQ-016 For an accepted command with `cmd_len` = 0, the block SHALL produce no beats and SHALL remain in IDLE.
REQ-017 For any other accepted command, the block SHALL enter COPY on the next cycle.
- `remaining` SHALL load `cmd_len`.
- `offset` SHALL be latched.
REQ-018 In COPY, `copy_valid` SHALL be 1 and the beat SHALL be defined as follows:
- n = min(remaining, 4, offset).
- `copy_bytes` = n.
- `rd_addr` = wr_addr - offset.
REQ-019 All beat outputs SHALL be registered, giving one cycle of latency from command accept to the first beat.
REQ-020 When `copy_valid` and `copy_ready` are both 1, the block SHALL update as follows:
- `wr_addr` += n.
- `remaining` -= n.
- If remaining equals n, the next state SHALL be IDLE.
REQ-021 If `copy_ready` is 0, all beat outputs SHALL hold stable.
REQ-022 Overlap handling: when offset < 4, each beat SHALL carry at most `offset` bytes, so that source bytes are always already written.
REQ-023 All address arithmetic SHALL be modulo 2^32 and SHALL wrap silently.
REQ-024 Back-to-back operation: `cmd_ready` SHALL be 1 in the cycle after the final beat handshake.

Reset
REQ-025 While `rstN` = 0, the block SHALL force the following values, at any time including mid-copy:
- State IDLE.
- `wr_addr`, `rd_addr`, `remaining`: 0.
- `copy_valid`, `copy_bytes`, `err_offset`: 0.
- `cmd_ready`: 1 after release.
REQ-026 Reset SHALL abandon any partially copied match with no further beats.

Configuration
REQ-027 The block SHALL use the macro LZ4_OFFSET_CHECK_EN to compile offset checking in or out.
REQ-028 With LZ4_OFFSET_CHECK_EN defined, an accepted command SHALL be treated as illegal when `cmd_offset` = 0 or `cmd_offset` > base address.
- An illegal command SHALL be consumed with no beats.
- The state SHALL stay IDLE.
- `err_offset` SHALL be set and held until reset.
REQ-029 Without LZ4_OFFSET_CHECK_EN, no offset check SHALL exist and `err_offset` SHALL be tied to 0.
- A command with offset 0 SHALL produce undefined addresses and SHALL still terminate after `cmd_len` bytes.

Verification
REQ-030 Literal tracking: after reset, `lit_incr` = 5, 3, 7 on three IDLE cycles -> `wr_addr` = 15.
REQ-031 Simple match: `wr_addr` = 100, command offset 20, len 10, `copy_ready` = 1 -> the bench SHALL see three beats:
- (rd 80, wr 100, 4).
- (84, 104, 4).
- (88, 108, 2).
- Then `wr_addr` = 110 and `cmd_ready` = 1.
REQ-032 Overlap: `wr_addr` = 50, offset 1, len 5 -> the bench SHALL see five beats of 1 byte with rd = 49, 50, 51, 52, 53.
- With offset 3, len 7, the beats SHALL be 3, 3, 1 bytes.
REQ-033 Stall and literal ignore: `copy_ready` = 0 for 3 cycles on the second beat -> `rd_addr`, `wr_addr` and `copy_bytes` SHALL stay constant.
- `lit_incr` = 7 during COPY -> `wr_addr` SHALL be unaffected.
REQ-034 Boundaries:
- `wr_addr` = 0xFFFFFFFE, offset 2, len 4 -> two beats of 2 bytes, and `wr_addr` SHALL wrap to 2.
- `cmd_len` = 0 -> no beat.
- With LZ4_OFFSET_CHECK_EN, `wr_addr` = 10 and offset 11 -> no beat and `err_offset` = 1.
REQ-035 Reset mid-copy: assert `rstN` during the second beat of a len 16 match -> all outputs SHALL be 0 and the next command SHALL start from `wr_addr` = 0.
